// File: rtl/fetch_pc_gen.sv
// Next-PC generator and ICache fetch-request issuer for the pre-IF stage.
// Redirects are prioritised, held until accepted, and in-flight responses are tagged for discard on flush/eret.
module fetch_pc_gen #(
    parameter int                 ADDR_W     = 32,
    parameter int                 FETCH_W    = 2,
    parameter int                 MAX_OUT    = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC   = 32'hbfc00000,
    parameter logic [ADDR_W-1:0]  EXC_VEC    = 32'hbfc00380,
    parameter logic [ADDR_W-1:0]  REFILL_VEC = 32'hbfc00200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fs_allowin,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              flush,
    input  logic              flush_refill,
    input  logic              eret,
    input  logic [ADDR_W-1:0] epc,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_pc,
    output logic [FETCH_W-1:0] req_mask,
    output logic              resp_discard,
    output logic              ps_ex,
    output logic [4:0]        ps_excode
);

    localparam int                LOG_W = $clog2(FETCH_W);
    localparam logic [ADDR_W-1:0] BLK   = ADDR_W'(FETCH_W * 4);

    logic [ADDR_W-1:0] r_pc, r_pend_pc;
    logic              r_pend_v, r_ex;
    logic [1:0]        r_pend_pri;
    logic [2:0]        r_out, r_disc;

    logic [1:0]        w_redir_pri;
    logic [ADDR_W-1:0] w_redir_pc, w_cur;
    logic              w_take_new, w_mis, w_kill, w_req_valid, w_acc, w_dok;

    always_comb begin
        w_redir_pri = 2'd0;
        w_redir_pc  = br_target;
        if (eret) begin
            w_redir_pri = 2'd3;
            w_redir_pc  = epc;
        end else if (flush) begin
            w_redir_pri = 2'd2;
            w_redir_pc  = flush_refill ? REFILL_VEC : EXC_VEC;
        end else if (br_taken) begin
            w_redir_pri = 2'd1;
        end
    end

    // A pending target that already faulted can never issue, so any redirect replaces it.
    assign w_take_new  = (w_redir_pri != 2'd0) &&
                         (!r_pend_v || (w_redir_pri >= r_pend_pri) || r_ex);
    assign w_cur       = w_take_new ? w_redir_pc : (r_pend_v ? r_pend_pc : r_pc);
    assign w_mis       = (w_cur[1:0] != 2'b00);
    assign w_kill      = flush | eret;
    assign w_req_valid = reset & fs_allowin & (~stall | w_kill) & ~r_ex & ~w_mis &
                         (r_out < 3'(MAX_OUT));
    assign w_acc       = w_req_valid & inst_addr_ok;
    assign w_dok       = inst_data_ok & (r_out != 3'd0);

    generate
        if (FETCH_W == 1) begin : g_mask1
            assign req_mask = 1'b1;
        end else begin : g_maskn
            logic [LOG_W-1:0] w_k;
            assign w_k = w_cur[LOG_W+1:2];
            for (genvar i = 0; i < FETCH_W; i++) begin : g_bit
                assign req_mask[i] = (LOG_W'(i) >= w_k);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_pend_v   <= 1'b0;
            r_pend_pc  <= '0;
            r_pend_pri <= 2'd0;
            r_ex       <= 1'b0;
            r_out      <= 3'd0;
            r_disc     <= 3'd0;
        end else begin
            if (w_acc)
                r_pc <= (w_cur & ~(BLK - ADDR_W'(1))) + BLK;

            if (w_acc) begin
                r_pend_v <= 1'b0;
            end else if (w_take_new) begin
                r_pend_v   <= 1'b1;
                r_pend_pc  <= w_redir_pc;
                r_pend_pri <= w_redir_pri;
            end

            // A misaligned new target wins over the clear of the redirect that produced it.
            if (w_mis)
                r_ex <= 1'b1;
            else if (w_kill)
                r_ex <= 1'b0;

            case ({w_acc, w_dok})
                2'b10:   r_out <= r_out + 3'd1;
                2'b01:   r_out <= r_out - 3'd1;
                default: r_out <= r_out;
            endcase

            // Requests accepted in the kill cycle belong to the new target and are not counted.
            if (w_kill)
                r_disc <= r_out - {2'b00, w_dok};
            else if (inst_data_ok && r_disc != 3'd0)
                r_disc <= r_disc - 3'd1;
        end
    end

    assign req_valid    = w_req_valid;
    assign req_pc       = w_cur;
    assign resp_discard = inst_data_ok & (r_disc != 3'd0);
    assign ps_ex        = r_ex;
    assign ps_excode    = r_ex ? 5'h04 : 5'h00;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: expected accepts/responses are queued at drive time and
// compared when the DUT accepts a request or returns a response.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_allowin, stall, br_taken, flush, flush_refill, eret;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] br_target, epc;
    logic        req_valid, resp_discard, ps_ex;
    logic [31:0] req_pc;
    logic [1:0]  req_mask;
    logic [4:0]  ps_excode;

    int errors = 0;
    int checks = 0;

    logic [31:0] q_pc[$];
    logic [1:0]  q_mask[$];
    logic        q_disc[$];

    fetch_pc_gen dut (
        .clk(clk), .reset(reset), .fs_allowin(fs_allowin), .stall(stall),
        .br_taken(br_taken), .br_target(br_target), .flush(flush),
        .flush_refill(flush_refill), .eret(eret), .epc(epc),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .req_valid(req_valid), .req_pc(req_pc), .req_mask(req_mask),
        .resp_discard(resp_discard), .ps_ex(ps_ex), .ps_excode(ps_excode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_acc(input logic [31:0] pc, input logic [1:0] m);
        q_pc.push_back(pc);
        q_mask.push_back(m);
    endtask

    task automatic exp_rsp(input logic d);
        q_disc.push_back(d);
    endtask

    // Advance one cycle; pulse-type inputs drop back to idle afterwards.
    task automatic step();
        @(posedge clk);
        #1;
        br_taken = 0; flush = 0; flush_refill = 0; eret = 0;
        inst_addr_ok = 0; inst_data_ok = 0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (req_valid && inst_addr_ok) begin
                if (q_pc.size() == 0) chk("unexpected_accept", {32'h0, req_pc}, 64'hffffffff);
                else begin
                    chk("acc_pc", {32'h0, req_pc}, {32'h0, q_pc.pop_front()});
                    chk("acc_mask", {62'h0, req_mask}, {62'h0, q_mask.pop_front()});
                end
            end
            if (inst_data_ok) begin
                if (q_disc.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
                else chk("resp_discard", {63'h0, resp_discard}, {63'h0, q_disc.pop_front()});
            end
        end
    end

    initial begin
        reset = 0; fs_allowin = 1; stall = 0; br_taken = 0; flush = 0; flush_refill = 0;
        eret = 0; inst_addr_ok = 0; inst_data_ok = 0; br_target = '0; epc = '0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", {63'h0, req_valid}, 64'd0);
        chk("rst_discard", {63'h0, resp_discard}, 64'd0);
        chk("rst_ps_ex", {63'h0, ps_ex}, 64'd0);
        chk("rst_excode", {59'h0, ps_excode}, 64'd0);
        chk("rst_pc", {32'h0, req_pc}, 64'hbfc00000);
        @(posedge clk); #1;
        reset = 1;

        // Sequential fetch
        inst_addr_ok = 1; exp_acc(32'hbfc00000, 2'b11); step();
        inst_addr_ok = 1; inst_data_ok = 1; exp_rsp(0); exp_acc(32'hbfc00008, 2'b11); step();
        inst_addr_ok = 1; inst_data_ok = 1; exp_rsp(0); exp_acc(32'hbfc00010, 2'b11); step();
        inst_data_ok = 1; exp_rsp(0);
        @(negedge clk); chk("seq_pc", {32'h0, req_pc}, 64'hbfc00018);
        step();

        // Branch held while ICache refuses
        br_taken = 1; br_target = 32'h80000014;
        @(negedge clk); chk("br_pc0", {32'h0, req_pc}, 64'h80000014);
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("br_hold_pc", {32'h0, req_pc}, 64'h80000014);
            chk("br_hold_valid", {63'h0, req_valid}, 64'd1);
            step();
        end
        inst_addr_ok = 1; exp_acc(32'h80000014, 2'b10); step();
        inst_addr_ok = 1; exp_acc(32'h80000018, 2'b11); step();
        inst_data_ok = 1; exp_rsp(0); step();
        inst_data_ok = 1; exp_rsp(0); step();

        // Refill flush with two requests outstanding
        inst_addr_ok = 1; exp_acc(32'h80000020, 2'b11); step();
        inst_addr_ok = 1; exp_acc(32'h80000028, 2'b11); step();
        flush = 1; flush_refill = 1; inst_addr_ok = 1;
        @(negedge clk);
        chk("flush_pc", {32'h0, req_pc}, 64'hbfc00200);
        chk("flush_full_valid", {63'h0, req_valid}, 64'd0);
        step();
        inst_data_ok = 1; inst_addr_ok = 1; exp_rsp(1); step();
        inst_data_ok = 1; inst_addr_ok = 1; exp_rsp(1); exp_acc(32'hbfc00200, 2'b11); step();
        inst_data_ok = 1; exp_rsp(0); step();

        // All three redirects in one cycle
        inst_addr_ok = 1; exp_acc(32'hbfc00208, 2'b11); step();
        br_taken = 1; br_target = 32'h80000500; flush = 1; eret = 1; epc = 32'h80001000;
        inst_addr_ok = 1; exp_acc(32'h80001000, 2'b11);
        @(negedge clk); chk("prio_pc", {32'h0, req_pc}, 64'h80001000);
        step();
        inst_data_ok = 1; exp_rsp(1); step();
        inst_data_ok = 1; exp_rsp(0); step();

        // Misaligned eret target, cleared by a flush
        eret = 1; epc = 32'h80000002; inst_addr_ok = 1;
        @(negedge clk); chk("mis_valid", {63'h0, req_valid}, 64'd0);
        step();
        for (int i = 0; i < 2; i++) begin
            inst_addr_ok = 1;
            @(negedge clk);
            chk("ex_ps_ex", {63'h0, ps_ex}, 64'd1);
            chk("ex_excode", {59'h0, ps_excode}, 64'h04);
            chk("ex_valid", {63'h0, req_valid}, 64'd0);
            step();
        end
        flush = 1; inst_addr_ok = 1;
        @(negedge clk); chk("exflush_pc", {32'h0, req_pc}, 64'hbfc00380);
        step();
        inst_addr_ok = 1; exp_acc(32'hbfc00380, 2'b11);
        @(negedge clk);
        chk("exclr_ps_ex", {63'h0, ps_ex}, 64'd0);
        chk("exclr_excode", {59'h0, ps_excode}, 64'd0);
        step();
        inst_data_ok = 1; exp_rsp(0); step();

        // Outstanding limit and simultaneous accept/response
        inst_addr_ok = 1; exp_acc(32'hbfc00388, 2'b11); step();
        inst_addr_ok = 1; exp_acc(32'hbfc00390, 2'b11); step();
        inst_addr_ok = 1;
        @(negedge clk); chk("limit_valid", {63'h0, req_valid}, 64'd0);
        step();
        inst_data_ok = 1; inst_addr_ok = 1; exp_rsp(0); step();
        inst_data_ok = 1; inst_addr_ok = 1; exp_rsp(0); exp_acc(32'hbfc00398, 2'b11); step();
        inst_addr_ok = 1; exp_acc(32'hbfc003a0, 2'b11); step();
        @(negedge clk); chk("limit2_valid", {63'h0, req_valid}, 64'd0);
        step();
        inst_data_ok = 1; exp_rsp(0); step();
        inst_data_ok = 1; exp_rsp(0); step();

        // Address wrap
        br_taken = 1; br_target = 32'hfffffff8; inst_addr_ok = 1;
        exp_acc(32'hfffffff8, 2'b11); step();
        inst_addr_ok = 1; exp_acc(32'h00000000, 2'b11); step();
        @(negedge clk); chk("wrap_pc", {32'h0, req_pc}, 64'h00000008);
        step();

        // Reset mid-operation with requests outstanding
        reset = 0;
        #1;
        chk("mrst_valid", {63'h0, req_valid}, 64'd0);
        chk("mrst_pc", {32'h0, req_pc}, 64'hbfc00000);
        step();
        reset = 1;
        inst_addr_ok = 1; exp_acc(32'hbfc00000, 2'b11); step();
        inst_data_ok = 1; exp_rsp(0); step();

        chk("sb_acc_empty", 64'(q_pc.size()), 64'd0);
        chk("sb_rsp_empty", 64'(q_disc.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
